// File: rtl/jericalla_pipe_gen.sv
// Three-stage Jericalla datapath (S0 decode/read, S1 execute, S2 memory/writeback)
// with valid/ready intake, ALU and load forwarding, load-use stall and hardwired R0.
module jericalla_pipe_gen #(
  parameter  int DATA_W  = 32,
  parameter  int RA_W    = 5,
  parameter  int RAM_AW  = 6,
  localparam int INSTR_W = 3 + 3 * RA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               zf,
  output logic               out_valid,
  output logic [DATA_W-1:0]  data_out
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_LI  = 3'b101,
    OP_SW  = 3'b110,
    OP_LW  = 3'b111
  } op_e;

  logic [DATA_W-1:0] r_regs [2**RA_W];
  logic [DATA_W-1:0] r_ram  [2**RAM_AW];

  logic              r_b1_valid;
  op_e               r_b1_op;
  logic [RA_W-1:0]   r_b1_wa;
  logic [DATA_W-1:0] r_b1_a;
  logic [DATA_W-1:0] r_b1_b;

  logic              r_b2_valid;
  op_e               r_b2_op;
  logic [RA_W-1:0]   r_b2_wa;
  logic [DATA_W-1:0] r_b2_res;
  logic [RAM_AW-1:0] r_b2_addr;
  logic [DATA_W-1:0] r_b2_data;

  logic              r_zf;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_data_out;

  op_e               w_op;
  logic [RA_W-1:0]   w_wa;
  logic [RA_W-1:0]   w_ra1;
  logic [RA_W-1:0]   w_ra2;
  logic [DATA_W-1:0] w_opa;
  logic [DATA_W-1:0] w_opb;
  logic [DATA_W-1:0] w_s1_res;
  logic [DATA_W-1:0] w_ram_rd;
  logic [DATA_W-1:0] w_b2_wb;
  logic              w_b1_wr;
  logic              w_b2_wr;
  logic              w_b1_lw;
  logic              w_stall;
  logic              w_accept;

  function automatic logic isAlu(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  assign w_op  = op_e'(instr[INSTR_W-1 -: 3]);
  assign w_wa  = instr[3*RA_W-1 -: RA_W];
  assign w_ra1 = instr[2*RA_W-1 -: RA_W];
  assign w_ra2 = instr[RA_W-1:0];

  assign w_ram_rd = r_ram[r_b2_addr];
  assign w_b2_wb  = (r_b2_op == OP_LW) ? w_ram_rd : r_b2_res;
  assign w_b1_wr  = r_b1_valid && (r_b1_wa != '0) && (isAlu(r_b1_op) || r_b1_op == OP_LI);
  assign w_b2_wr  = r_b2_valid && (r_b2_wa != '0) &&
                    (isAlu(r_b2_op) || r_b2_op == OP_LI || r_b2_op == OP_LW);

  // A load in B1 has no data until S2, so a dependent reader waits one cycle.
  assign w_b1_lw  = r_b1_valid && (r_b1_op == OP_LW) && (r_b1_wa != '0);
  assign w_stall  = w_b1_lw &&
                    (((w_ra1 == r_b1_wa) && (isAlu(w_op) || w_op == OP_SW || w_op == OP_LW)) ||
                     ((w_ra2 == r_b1_wa) && (isAlu(w_op) || w_op == OP_SW)));
  assign in_ready = !w_stall;
  assign w_accept = in_valid && !w_stall;

  function automatic logic [DATA_W-1:0] readOperand(input logic [RA_W-1:0] ra);
    logic [DATA_W-1:0] val;
    val = r_regs[ra];
    if (ra == '0)
      val = '0;
    else if (w_b1_wr && (r_b1_wa == ra))
      val = w_s1_res;
    else if (w_b2_wr && (r_b2_wa == ra))
      val = w_b2_wb;
    return val;
  endfunction

  always_comb begin
    w_opa = readOperand(w_ra1);
    w_opb = readOperand(w_ra2);
    if (w_op == OP_LI)
      w_opb = DATA_W'({w_ra1, w_ra2});
  end

  always_comb begin
    w_s1_res = '0;
    case (r_b1_op)
      OP_ADD:  w_s1_res = r_b1_a + r_b1_b;
      OP_SUB:  w_s1_res = r_b1_a - r_b1_b;
      OP_AND:  w_s1_res = r_b1_a & r_b1_b;
      OP_OR:   w_s1_res = r_b1_a | r_b1_b;
      OP_LI:   w_s1_res = r_b1_b;
      default: w_s1_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b1_valid <= 1'b0;
      r_b1_op    <= OP_NOP;
      r_b1_wa    <= '0;
      r_b1_a     <= '0;
      r_b1_b     <= '0;
      r_b2_valid <= 1'b0;
      r_b2_op    <= OP_NOP;
      r_b2_wa    <= '0;
      r_b2_res   <= '0;
      r_b2_addr  <= '0;
      r_b2_data  <= '0;
      r_zf       <= 1'b0;
    end else begin
      r_b1_valid <= w_accept;
      r_b1_op    <= w_op;
      r_b1_wa    <= w_wa;
      r_b1_a     <= w_opa;
      r_b1_b     <= w_opb;
      r_b2_valid <= r_b1_valid;
      r_b2_op    <= r_b1_op;
      r_b2_wa    <= r_b1_wa;
      r_b2_res   <= w_s1_res;
      r_b2_addr  <= r_b1_a[RAM_AW-1:0];
      r_b2_data  <= r_b1_b;
      if (r_b1_valid && isAlu(r_b1_op))
        r_zf <= (w_s1_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**RA_W; i++)
        r_regs[i] <= '0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (w_b2_wr)
        r_regs[r_b2_wa] <= w_b2_wb;
      r_out_valid <= r_b2_valid && (r_b2_op == OP_LW);
      if (r_b2_valid && (r_b2_op == OP_LW))
        r_data_out <= w_ram_rd;
    end
  end

  // RAM contents survive reset; a store only lands from a valid B2 entry.
  always_ff @(posedge clk) begin
    if (r_b2_valid && (r_b2_op == OP_SW))
      r_ram[r_b2_addr] <= r_b2_data;
  end

  assign zf        = r_zf;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_jericalla_pipe_gen.sv
// Directed bench for jericalla_pipe_gen: load results checked through a scoreboard
// queue, flags/stalls/register contents checked at fixed points of the sequence.
module tb_jericalla_pipe_gen;

  localparam int DATA_W  = 32;
  localparam int RA_W    = 5;
  localparam int RAM_AW  = 6;
  localparam int INSTR_W = 3 + 3 * RA_W;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               zf;
  logic               out_valid;
  logic [DATA_W-1:0]  data_out;

  int checks = 0;
  int errors = 0;
  int lwIssued = 0;
  int lwSeen = 0;
  logic [DATA_W-1:0] expQ [$];

  jericalla_pipe_gen #(.DATA_W(DATA_W), .RA_W(RA_W), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .zf(zf), .out_valid(out_valid), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every load completion is matched against the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      lwSeen++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        checkOutput("lw_data_out", data_out, expQ.pop_front());
      end
    end
  end

  // Drives one instruction and holds it until accepted; reports cycles spent stalled.
  task automatic applyStimulus(input logic [2:0] op, input int wa, input int ra1,
                               input int ra2, output int stalls);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = {op, RA_W'(wa), RA_W'(ra1), RA_W'(ra2)};
    stalls   = 0;
    #1;
    while (!in_ready && stalls < 4) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!in_ready) begin
      $display("[TB] FAIL in_ready_timeout observed=0 expected=1");
      $fatal(1, "[TB] handshake stuck");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (op == 3'b111) lwIssued++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int st;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_zf", zf, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Step 1: back-to-back LI/LI/ADD with forwarding from B2 and B1
    applyStimulus(3'b101, 1, 0, 5, st);
    applyStimulus(3'b101, 2, 0, 3, st);
    applyStimulus(3'b001, 3, 1, 2, st);
    checkOutput("add_no_stall", st, 0);
    idle(2);
    checkOutput("r3_sum", dut.r_regs[3], 8);
    checkOutput("add_zf", zf, 0);

    // Step 2: SUB to zero sets zf when it enters B2
    applyStimulus(3'b010, 4, 1, 1, st);
    checkOutput("sub_zf_before", zf, 0);
    @(posedge clk); #1;
    checkOutput("sub_zf_after", zf, 1);
    idle(1);

    // Step 3: store then immediate load of the same address
    applyStimulus(3'b110, 0, 1, 3, st);
    expQ.push_back(8);
    applyStimulus(3'b111, 5, 1, 0, st);
    checkOutput("sw_lw_no_stall", st, 0);
    idle(3);
    checkOutput("lw_pulses", lwSeen, lwIssued);
    checkOutput("r5_loaded", dut.r_regs[5], 8);
    checkOutput("sw_zf_hold", zf, 1);

    // Step 4: load-use stall then forward load data
    expQ.push_back(8);
    applyStimulus(3'b111, 5, 1, 0, st);
    applyStimulus(3'b001, 6, 5, 2, st);
    checkOutput("load_use_stall", st, 1);
    idle(3);
    checkOutput("r6_fwd_load", dut.r_regs[6], 11);
    checkOutput("add_zf_clear", zf, 0);

    // Step 5: writes to R0 are dropped
    applyStimulus(3'b101, 7, 0, 9, st);
    applyStimulus(3'b101, 0, 0, 7, st);
    applyStimulus(3'b001, 7, 0, 0, st);
    idle(3);
    checkOutput("r7_zero", dut.r_regs[7], 0);
    checkOutput("r0_zf", zf, 1);
    checkOutput("r0_stays", dut.r_regs[0], 0);

    // Store data forwarded from B1, then load through a B2-forwarded address
    applyStimulus(3'b101, 8, 0, 21, st);
    applyStimulus(3'b110, 0, 8, 8, st);
    expQ.push_back(21);
    applyStimulus(3'b111, 9, 8, 0, st);
    idle(3);
    checkOutput("r9_loaded", dut.r_regs[9], 21);
    checkOutput("lw_pulses_2", lwSeen, lwIssued);

    // Step 6: reset while a store sits in B1
    applyStimulus(3'b110, 0, 1, 2, st);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_zf", zf, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_r1", dut.r_regs[1], 0);
    checkOutput("rst_r6", dut.r_regs[6], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rst_data_out", data_out, 0);
    applyStimulus(3'b101, 1, 0, 5, st);
    expQ.push_back(8);
    applyStimulus(3'b111, 5, 1, 0, st);
    idle(3);
    checkOutput("ram5_kept", data_out, 8);
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("lw_pulses_3", lwSeen, lwIssued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
